// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants and FSM state type for the I2S transmit/receive stages
package i2s_pkg;

    localparam int WIDTH_DEFAULT = 16;

    // Word-select polarity shared with the receive/XOR stage.
    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } i2s_state_t;

endpackage

// File: rtl/i2s_tx_shifter.sv
// rtl/i2s_tx_shifter.sv - frame shift register and bit counter driving sd/ws
module i2s_tx_shifter
    import i2s_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 sck,
    input  logic                 rst,
    input  logic                 active,
    input  logic                 load,
    input  logic [2*WIDTH-1:0]   load_data,
    output logic                 sd,
    output logic                 ws,
    output logic                 frame_end
);

    localparam int FRAME = 2 * WIDTH;
    localparam int CW    = $clog2(FRAME);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
    localparam logic [CW-1:0] HALF = CW'(WIDTH - 1);

    logic [FRAME-1:0] sreg;
    logic [CW-1:0]    cnt;

    // cnt holds the number of edges since E0, so LAST marks the edge that closes the frame.
    assign frame_end = active && (cnt == LAST);

    // The register always shifts so it is all-zero once a frame drains, giving sd=0 when idle.
    always_ff @(posedge sck or negedge rst) begin
        if (!rst) begin
            sreg <= '0;
            cnt  <= '0;
            sd   <= 1'b0;
            ws   <= WS_RIGHT;
        end else begin
            sd <= sreg[FRAME-1];
            if (load) begin
                sreg <= load_data;
                cnt  <= '0;
                ws   <= WS_LEFT;
            end else begin
                sreg <= {sreg[FRAME-2:0], 1'b0};
                if (active) begin
                    cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
                    if (cnt == HALF) begin
                        ws <= WS_RIGHT;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - I2S transmitter: sample handshake, holding register, frame FSM
module i2s_tx_serializer
    import i2s_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             sck,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] smp_left,
    input  logic [WIDTH-1:0] smp_right,
    input  logic             smp_valid,
    output logic             smp_ready,
    output logic             sd,
    output logic             ws,
    output logic             frame_start,
    output logic             underrun,
    output logic             busy
);

    i2s_state_t         state, state_nxt;
    logic [2*WIDTH-1:0] hold_data;
    logic               hold_full;
    logic               frame_end;
    logic               load_now;
    logic               underrun_nxt;
    logic               xfer;

    always_comb begin
        state_nxt    = state;
        load_now     = 1'b0;
        underrun_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en && hold_full) begin
                    load_now  = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // en only matters at the frame boundary; an empty hold still starts a silent frame.
                if (frame_end) begin
                    if (en) begin
                        load_now     = 1'b1;
                        underrun_nxt = !hold_full;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign smp_ready = !hold_full || load_now;
    assign xfer      = smp_valid && smp_ready;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge sck or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_nxt;
            frame_start <= load_now;
            underrun    <= underrun_nxt;
            if (xfer) begin
                hold_data <= {smp_left, smp_right};
                hold_full <= 1'b1;
            end else if (load_now) begin
                hold_full <= 1'b0;
            end
        end
    end

    i2s_tx_shifter #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .sck       (sck),
        .rst       (rst),
        .active    (state == ST_RUN),
        .load      (load_now),
        .load_data (hold_full ? hold_data : '0),
        .sd        (sd),
        .ws        (ws),
        .frame_end (frame_end)
    );

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb/tb_i2s_tx_serializer.sv - scoreboard bench for i2s_tx_serializer
module tb_i2s_tx_serializer;

    localparam int W = 16;

    logic         sck;
    logic         rst;
    logic         en;
    logic [W-1:0] smp_left;
    logic [W-1:0] smp_right;
    logic         smp_valid;
    logic         smp_ready;
    logic         sd;
    logic         ws;
    logic         frame_start;
    logic         underrun;
    logic         busy;

    i2s_tx_serializer #(.WIDTH(W)) dut (
        .sck         (sck),
        .rst         (rst),
        .en          (en),
        .smp_left    (smp_left),
        .smp_right   (smp_right),
        .smp_valid   (smp_valid),
        .smp_ready   (smp_ready),
        .sd          (sd),
        .ws          (ws),
        .frame_start (frame_start),
        .underrun    (underrun),
        .busy        (busy)
    );

    typedef struct {
        int          acc;
        logic [31:0] data;
    } pair_t;

    pair_t       q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic        mon_on = 1'b0;
    logic        in_frame = 1'b0;
    int          k = 0;
    int          idle_cnt = 1;
    logic [31:0] cur = '0;
    logic        exp_next = 1'b0;
    logic        exp_ur;

    initial sck = 1'b0;
    always #5 sck = ~sck;
    always @(posedge sck) cyc <= cyc + 1;

    task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string name);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A pair belongs to the frame whose E0 comes strictly after the edge that accepted it.
    always begin
        @(negedge sck);
        #1;
        if (mon_on) begin
            if (underrun && !frame_start) chk(1, 0, "underrun_outside_e0");
            if (in_frame) begin
                k++;
                chk(sd, cur[2*W-k], "sd_bit");
                if (k < 2*W) begin
                    chk(ws, (k >= W) ? 1 : 0, "ws_slot");
                    if (frame_start) chk(1, 0, "frame_start_midframe");
                    if (k == 2*W-1) exp_next = en;
                end else begin
                    chk(frame_start, exp_next, "frame_continuation");
                    if (!frame_start) chk(ws, 1, "ws_after_frame");
                    in_frame = 1'b0;
                    idle_cnt = 0;
                end
            end else if (!frame_start) begin
                chk(ws, 1, "idle_ws");
                if (idle_cnt > 0) chk(sd, 0, "idle_sd");
                idle_cnt++;
            end
            if (frame_start && !in_frame) begin
                if (q.size() > 0 && q[0].acc < cyc) begin
                    cur = q[0].data;
                    void'(q.pop_front());
                    exp_ur = 1'b0;
                end else begin
                    cur = '0;
                    exp_ur = 1'b1;
                end
                chk(underrun, exp_ur, "underrun_flag");
                chk(ws, 0, "ws_e0");
                in_frame = 1'b1;
                k = 0;
            end
        end
    end

    task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
        int n;
        n = 0;
        smp_left  = l;
        smp_right = r;
        smp_valid = 1'b1;
        #1;
        while (!smp_ready && n < 300) begin
            @(negedge sck);
            #1;
            n++;
        end
        if (!smp_ready) begin
            chk(0, 1, "send_ready_timeout");
        end else begin
            q.push_back('{acc: cyc + 1, data: {l, r}});
        end
        @(negedge sck);
        smp_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) @(negedge sck);
        chk(busy, 0, "idle_timeout");
    endtask

    initial begin
        rst = 1'b0;
        en = 1'b0;
        smp_valid = 1'b0;
        smp_left = '0;
        smp_right = '0;
        repeat (3) @(negedge sck);
        chk(sd, 0, "reset_sd");
        chk(ws, 1, "reset_ws");
        chk(smp_ready, 1, "reset_ready");
        chk(busy, 0, "reset_busy");
        chk(frame_start, 0, "reset_frame_start");
        rst = 1'b1;
        @(negedge sck);
        mon_on = 1'b1;

        // Single frame followed by an underrun frame.
        en = 1'b1;
        send(16'hA5C3, 16'h8001);
        chk(frame_start, 0, "latency_pre_e0");
        @(negedge sck);
        chk(frame_start, 1, "latency_e0");
        repeat (40) @(negedge sck);
        en = 1'b0;
        wait_idle();
        repeat (2) @(negedge sck);
        chk(ws, 1, "idle_ws_a");
        chk(sd, 0, "idle_sd_a");
        chk(smp_ready, 1, "idle_ready_a");

        // Back-to-back pairs with valid held.
        en = 1'b1;
        send(16'h1234, 16'hFEDC);
        send(16'($urandom), 16'($urandom));
        chk(smp_ready, 0, "ready_low_hold_full_2");
        send(16'($urandom), 16'($urandom));
        chk(smp_ready, 0, "ready_low_hold_full_3");
        repeat (40) @(negedge sck);
        en = 1'b0;
        wait_idle();

        // en drop mid-frame with a second pair held; second pair accepted at E0.
        en = 1'b1;
        send(16'h0F0F, 16'h7FFE);
        send(16'hC001, 16'h5AA5);
        repeat (7) @(negedge sck);
        en = 1'b0;
        repeat (40) @(negedge sck);
        chk(busy, 0, "drop_busy");
        chk(ws, 1, "drop_ws");
        chk(sd, 0, "drop_sd");
        chk(smp_ready, 0, "drop_ready_held");
        en = 1'b1;
        @(negedge sck);
        chk(frame_start, 1, "resume_e0");
        en = 1'b0;
        wait_idle();

        // Randomized pairs with random gaps, exercising underruns.
        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 45)) @(negedge sck);
            send(16'($urandom), 16'($urandom));
        end
        repeat (70) @(negedge sck);
        en = 1'b0;
        wait_idle();
        repeat (2) @(negedge sck);
        chk(q.size(), 0, "queue_drained");

        // Asynchronous reset in the middle of a frame.
        en = 1'b1;
        send(16'hFFFF, 16'hFFFF);
        repeat (6) @(negedge sck);
        chk(sd, 1, "pre_reset_sd");
        chk(ws, 0, "pre_reset_ws");
        mon_on = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk(sd, 0, "async_reset_sd");
        chk(ws, 1, "async_reset_ws");
        chk(smp_ready, 1, "async_reset_ready");
        chk(busy, 0, "async_reset_busy");
        chk(underrun, 0, "async_reset_underrun");
        chk(frame_start, 0, "async_reset_frame_start");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
